if_stage_fetch: RTL and testbench



---
 rtl/if_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 32 +++
 rtl/if_stage_fetch.sv | 112 +++++++++++
 tb/tb_if_stage_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // PC register load-mux select.
    localparam logic [1:0] PC_SEL_HOLD = 2'd0;
    localparam logic [1:0] PC_SEL_INC  = 2'd1;
    localparam logic [1:0] PC_SEL_LOAD = 2'd2;

    localparam logic [31:0] NOP              = 32'd0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: hold, sequential step or redirect load.
module fetch_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // Step wraps modulo 2^32; target low bits are kept as given.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (i_sel)
                PC_SEL_INC:  r_pc <= r_pc + PC_STEP;
                PC_SEL_LOAD: r_pc <= i_target;
                default:     r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_stage_fetch.sv
// Fetch stage: owns the PC, runs req/ack with instruction memory and feeds IF/ID.
module if_stage_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        if_valid,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a word transfers at a posedge where imem_req=1 and imem_ack=1.
    // While imem_req=1 and no ack has occurred, imem_addr does not change.
    // IF/ID consumes the presented word when if_valid=1, freeze=0, branch_taken=0.

    fetch_state_t r_state;
    logic [31:0]  r_instr_q;
    logic [31:0]  r_drain_addr;
    logic [31:0]  w_pc;
    logic [1:0]   w_pc_sel;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .i_sel    (w_pc_sel),
        .i_target (branch_target),
        .o_pc     (w_pc)
    );

    always_comb begin
        w_pc_sel = PC_SEL_HOLD;
        case (r_state)
            ST_FETCH: begin
                if (branch_taken)
                    w_pc_sel = PC_SEL_LOAD;
                else if (imem_ack && !freeze)
                    w_pc_sel = PC_SEL_INC;
            end
            ST_HOLD: begin
                if (branch_taken)
                    w_pc_sel = PC_SEL_LOAD;
                else if (!freeze)
                    w_pc_sel = PC_SEL_INC;
            end
            ST_DRAIN: begin
                if (branch_taken)
                    w_pc_sel = PC_SEL_LOAD;
            end
            default: w_pc_sel = PC_SEL_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_instr_q    <= NOP;
            r_drain_addr <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (branch_taken && !imem_ack) begin
                        // The outstanding request must still complete at its own address.
                        r_drain_addr <= w_pc;
                        r_state      <= ST_DRAIN;
                    end else if (!branch_taken && imem_ack && freeze) begin
                        r_instr_q <= imem_rdata;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (branch_taken || !freeze)
                        r_state <= ST_FETCH;
                end
                ST_DRAIN: begin
                    if (imem_ack)
                        r_state <= ST_FETCH;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign imem_addr   = (r_state == ST_DRAIN) ? r_drain_addr : w_pc;
    assign if_valid    = ((r_state == ST_FETCH) && imem_ack) || (r_state == ST_HOLD);
    assign PC_out      = w_pc + PC_STEP;
    assign o_dbg_state = r_state;

    always_comb begin
        Instruction_out = NOP;
        if (r_state == ST_FETCH && imem_ack)
            Instruction_out = imem_rdata;
        else if (r_state == ST_HOLD)
            Instruction_out = r_instr_q;
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Randomized bench: memory model with variable latency, program-order reference model, scoreboard.
module tb_if_stage_fetch;

  localparam logic [31:0] RST_PC = 32'd0;
  localparam logic [31:0] STEP   = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic        if_valid;
  logic [1:0]  o_dbg_state;

  if_stage_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .if_valid        (if_valid),
    .o_dbg_state     (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int consumed = 0;
  int gap = 0;
  int lat_max = 0;
  int lat_fix = -1;
  int freeze_pct = 0;
  int branch_pct = 0;
  bit stray_ack = 0;
  bit after_reset = 0;

  // expected PC of the next instruction IF/ID should see, in program order
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 32'd0;

  always begin
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (!rst && imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_addr = imem_addr;
        mem_wait = (lat_fix >= 0) ? lat_fix : $urandom_range(0, lat_max);
      end else begin
        check("addr_stable", imem_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        mem_busy   = 0;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_busy = 0;
      imem_ack = stray_ack;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] cur;
    if (rst) begin
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_instr", Instruction_out, 32'd0);
      check("rst_pc_out", PC_out, RST_PC + STEP);
      exp_q.delete();
      exp_q.push_back(RST_PC);
      gap = 0;
    end else begin
      if (after_reset) begin
        check("idle_valid", {31'd0, if_valid}, 32'd0);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        after_reset = 0;
      end
      if (if_valid) begin
        gap = 0;
        check("pc_out", PC_out, exp_q[0] + STEP);
        check("instr", Instruction_out, word_of(exp_q[0]));
        if (branch_taken) begin
          exp_q.delete();
          exp_q.push_back(branch_target);
        end else if (!freeze) begin
          cur = exp_q.pop_front();
          exp_q.push_back(cur + STEP);
          consumed++;
        end
      end else begin
        check("nop", Instruction_out, 32'd0);
        if (branch_taken) begin
          exp_q.delete();
          exp_q.push_back(branch_target);
        end
        gap++;
        if (gap == 40) begin
          checks++;
          errors++;
          $display("FAIL liveness: got %0d idle cycles expected under 40", gap);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    after_reset = 1;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return 32'hFFFF_FFF8;
      1:       return r;
      default: return {22'd0, r[7:0], 2'b00};
    endcase
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      freeze        = ($urandom_range(0, 99) < freeze_pct);
      branch_taken  = ($urandom_range(0, 99) < branch_pct);
      branch_target = pick_target();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    do_reset();

    // zero-wait memory, straight-line code: one instruction per cycle
    lat_max = 0; freeze_pct = 0; branch_pct = 0;
    c0 = consumed;
    run(30);
    check("zero_wait_rate", consumed - c0, 32'd29);

    // fixed 3-cycle latency, then random latency
    lat_fix = 2;
    run(40);
    lat_fix = -1;
    lat_max = 3;
    run(40);

    // random freeze / branch traffic across latencies
    for (int blk = 0; blk < 15; blk++) begin
      lat_max    = $urandom_range(0, 3);
      freeze_pct = $urandom_range(0, 35);
      branch_pct = $urandom_range(0, 12);
      run(100);
    end

    // reset in the middle of an outstanding request, stray ack while idle
    freeze_pct = 0; branch_pct = 0;
    freeze = 1'b0; branch_taken = 1'b0;
    lat_fix = 6;
    do_reset();
    run(2);
    #2;
    rst = 1'b1;
    #1;
    check("async_req_drop", {31'd0, imem_req}, 32'd0);
    check("async_pc_out", PC_out, RST_PC + STEP);
    stray_ack = 1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    after_reset = 1;
    @(posedge clk);
    stray_ack = 0;
    lat_fix = -1;
    #1;
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, RST_PC);

    lat_max = 3; freeze_pct = 20; branch_pct = 8;
    run(200);
    freeze = 1'b0; branch_taken = 1'b0;
    repeat (3) @(posedge clk);

    check("progress", {31'd0, consumed > 300}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
